// File: rtl/tag_rx_integrator.sv
// Integrate-and-dump of baseband I/Q over NLOC_PER_SYNC windows of NSIG samples after each sync,
// with scale/saturate, a small result FIFO and an AXI-stream master output.
module tag_rx_integrator #(
  parameter int DATA_WIDTH    = 16,
  parameter int NSIG          = 262144,
  parameter int NLOC_PER_SYNC = 3,
  parameter int ACC_WIDTH     = DATA_WIDTH + $clog2(NSIG) + 1,
  parameter int SHIFT         = 18,
  parameter int OUT_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 run,
  input  logic                                 sync_stb,
  input  logic                                 rx_valid,
  input  logic [DATA_WIDTH-1:0]                irx_in,
  input  logic [DATA_WIDTH-1:0]                qrx_in,
  output logic [2*OUT_WIDTH-1:0]               m_tdata,
  output logic [$clog2(NLOC_PER_SYNC+1)-1:0]   m_tuser,
  output logic                                 m_tlast,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 busy,
  output logic                                 overflow
);

  localparam int SW = $clog2(NSIG);
  localparam int UW = $clog2(NLOC_PER_SYNC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2*OUT_WIDTH + UW + 1;
  localparam logic [SW-1:0] SCNT_LAST = SW'(NSIG - 1);
  localparam logic [UW-1:0] LCNT_LAST = UW'(NLOC_PER_SYNC - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ARMED, ACCUM} state_t;

  state_t state, state_nxt;

  logic [SW-1:0]                 scnt;
  logic [UW-1:0]                 lcnt;
  logic signed [ACC_WIDTH-1:0]   acc_i, acc_q, xi, xq, sum_i, sum_q;
  logic                          start, take, win_last, seq_last;

  logic                          res_vld;
  logic [EW-1:0]                 res_ent;

  logic [EW-1:0]                 mem [FIFO_DEPTH];
  logic [AW-1:0]                 wptr, rptr;
  logic [AW:0]                   count;
  logic                          pop, wr_ok, drop, run_q;

  function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (sh < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                   return sh[OUT_WIDTH-1:0];
  endfunction

  assign xi = {{(ACC_WIDTH-DATA_WIDTH){irx_in[DATA_WIDTH-1]}}, irx_in};
  assign xq = {{(ACC_WIDTH-DATA_WIDTH){qrx_in[DATA_WIDTH-1]}}, qrx_in};

  // Samples are only taken while run is high, so a run drop never completes a window.
  assign start    = (state == ARMED) && run && sync_stb;
  assign take     = (state == ACCUM) && run && rx_valid;
  assign win_last = take && (scnt == SCNT_LAST);
  assign seq_last = win_last && (lcnt == LCNT_LAST);
  assign sum_i    = (scnt == '0) ? xi : acc_i + xi;
  assign sum_q    = (scnt == '0) ? xq : acc_q + xq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARMED;
        ARMED:   if (sync_stb) state_nxt = ACCUM;
        ACCUM:   if (seq_last) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ACCUM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt  <= '0;
      lcnt  <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (start) begin
      scnt  <= '0;
      lcnt  <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (take) begin
      acc_i <= sum_i;
      acc_q <= sum_q;
      if (win_last) begin
        scnt <= '0;
        lcnt <= lcnt + UW'(1);
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_vld <= 1'b0;
      res_ent <= '0;
    end else begin
      res_vld <= win_last;
      if (win_last) res_ent <= {sat(sum_i), sat(sum_q), lcnt, lcnt == LCNT_LAST};
    end
  end

  assign pop   = m_tvalid && m_tready;
  assign wr_ok = res_vld && ((count != FIFO_FULL) || pop);
  assign drop  = res_vld && !wr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= res_ent;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_tvalid = (count != '0);
  assign {m_tdata, m_tuser, m_tlast} = m_tvalid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      run_q <= run;
      if (drop)              overflow <= 1'b1;
      else if (run && !run_q) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tag_rx_integrator.sv
// Directed bench for tag_rx_integrator with NSIG=4, NLOC_PER_SYNC=3, SHIFT=0.
module tb_tag_rx_integrator;

  logic        clk = 1'b0;
  logic        reset_n, run, sync_stb, rx_valid, m_tready;
  logic [15:0] irx_in, qrx_in;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic        m_tlast, m_tvalid, busy, overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic [1:0]  q_user[$];
  logic        q_last[$];
  int          q_cyc[$];

  tag_rx_integrator #(
    .DATA_WIDTH(16), .NSIG(4), .NLOC_PER_SYNC(3), .SHIFT(0),
    .OUT_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sync_stb(sync_stb),
    .rx_valid(rx_valid), .irx_in(irx_in), .qrx_in(qrx_in),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_user.push_back(m_tuser);
      q_last.push_back(m_tlast);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] expd(input int i, input int q);
    logic [31:0] a, b;
    a = i;
    b = q;
    return {a[15:0], b[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    logic [31:0] a, b;
    a = i;
    b = q;
    rx_valid = 1'b1;
    irx_in   = a[15:0];
    qrx_in   = b[15:0];
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_stb = 1'b1;
    tick();
    sync_stb = 1'b0;
  endtask

  task automatic clear_beats();
    q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 40 && q_data.size() < n; k++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; sync_stb = 1'b0; rx_valid = 1'b0;
    m_tready = 1'b0; irx_in = '0; qrx_in = '0;
    #12;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    vectors++; if (m_tdata !== 32'h0) begin miscompares++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    vectors++; if (m_tuser !== 2'd0) begin miscompares++; $display("FAIL rst_tuser: got %0d want 0", m_tuser); end
    vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int dcyc[3];
    clear_beats();
    m_tready = 1'b1;
    run = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t1_busy_armed: got %b want 0", busy); end
    pulse_sync();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy_rise: got %b want 1", busy); end
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) dcyc[i/4-1] = cyc;
      send(i, -i);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t1_busy_fall: got %b want 0", busy); end
    wait_beats(3);
    vectors++; if (q_data.size() != 3) begin miscompares++; $display("FAIL t1_beats: got %0d want 3", q_data.size()); end
    for (int j = 0; j < 3 && j < q_data.size(); j++) begin
      vectors++; if (q_data[j] !== expd(10 + 16*j, -(10 + 16*j))) begin miscompares++; $display("FAIL t1_data[%0d]: got %h want %h", j, q_data[j], expd(10 + 16*j, -(10 + 16*j))); end
      vectors++; if (q_user[j] !== 2'(j)) begin miscompares++; $display("FAIL t1_user[%0d]: got %0d want %0d", j, q_user[j], j); end
      vectors++; if (q_last[j] !== (j == 2)) begin miscompares++; $display("FAIL t1_last[%0d]: got %b want %b", j, q_last[j], j == 2); end
      vectors++; if (q_cyc[j] != dcyc[j] + 3) begin miscompares++; $display("FAIL t1_latency[%0d]: got %0d want %0d", j, q_cyc[j], dcyc[j] + 3); end
    end
  endtask

  task automatic test_gapped();
    clear_beats();
    // Sync coincident with a sample that must not be counted.
    sync_stb = 1'b1; rx_valid = 1'b1; irx_in = 16'd100; qrx_in = -16'sd100;
    tick();
    sync_stb = 1'b0; rx_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      send(i, -i);
      if (i == 6) sync_stb = 1'b1;
      tick();
      sync_stb = 1'b0;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t2_busy_end: got %b want 0", busy); end
    wait_beats(3);
    vectors++; if (q_data.size() != 3) begin miscompares++; $display("FAIL t2_beats: got %0d want 3", q_data.size()); end
    for (int j = 0; j < 3 && j < q_data.size(); j++) begin
      vectors++; if (q_data[j] !== expd(10 + 16*j, -(10 + 16*j))) begin miscompares++; $display("FAIL t2_data[%0d]: got %h want %h", j, q_data[j], expd(10 + 16*j, -(10 + 16*j))); end
      vectors++; if (q_user[j] !== 2'(j)) begin miscompares++; $display("FAIL t2_user[%0d]: got %0d want %0d", j, q_user[j], j); end
      vectors++; if (q_last[j] !== (j == 2)) begin miscompares++; $display("FAIL t2_last[%0d]: got %b want %b", j, q_last[j], j == 2); end
    end
  endtask

  task automatic test_saturation();
    clear_beats();
    pulse_sync();
    for (int i = 0; i < 12; i++) send(32767, -32768);
    wait_beats(3);
    vectors++; if (q_data.size() != 3) begin miscompares++; $display("FAIL t3_beats: got %0d want 3", q_data.size()); end
    for (int j = 0; j < 3 && j < q_data.size(); j++) begin
      vectors++; if (q_data[j] !== 32'h7FFF_8000) begin miscompares++; $display("FAIL t3_data[%0d]: got %h want 7fff8000", j, q_data[j]); end
    end
  endtask

  task automatic test_backpressure();
    clear_beats();
    m_tready = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t4_ovf_before: got %b want 0", overflow); end
    for (int s = 0; s < 3; s++) begin
      pulse_sync();
      for (int i = 0; i < 12; i++) send(s + 1, -(s + 1));
    end
    repeat (4) tick();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t4_ovf_set: got %b want 1", overflow); end
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL t4_tvalid: got %b want 1", m_tvalid); end
    vectors++; if (m_tdata !== expd(4, -4)) begin miscompares++; $display("FAIL t4_head_data: got %h want %h", m_tdata, expd(4, -4)); end
    vectors++; if (m_tuser !== 2'd0) begin miscompares++; $display("FAIL t4_head_user: got %0d want 0", m_tuser); end
    vectors++; if (q_data.size() != 0) begin miscompares++; $display("FAIL t4_no_pop: got %0d want 0", q_data.size()); end
    m_tready = 1'b1;
    wait_beats(5);
    vectors++; if (q_data.size() != 4) begin miscompares++; $display("FAIL t4_drain: got %0d want 4", q_data.size()); end
    for (int j = 0; j < 4 && j < q_data.size(); j++) begin
      vectors++; if (q_data[j] !== ((j < 3) ? expd(4, -4) : expd(8, -8))) begin miscompares++; $display("FAIL t4_data[%0d]: got %h want %h", j, q_data[j], (j < 3) ? expd(4, -4) : expd(8, -8)); end
      vectors++; if (q_user[j] !== ((j < 3) ? 2'(j) : 2'd0)) begin miscompares++; $display("FAIL t4_user[%0d]: got %0d want %0d", j, q_user[j], (j < 3) ? j : 0); end
      vectors++; if (q_last[j] !== (j == 2)) begin miscompares++; $display("FAIL t4_last[%0d]: got %b want %b", j, q_last[j], j == 2); end
    end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL t4_empty: got %b want 0", m_tvalid); end
  endtask

  task automatic test_run_drop();
    clear_beats();
    pulse_sync();
    for (int i = 0; i < 6; i++) send(1, -1);
    run = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t5_busy_idle: got %b want 0", busy); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t5_ovf_held: got %b want 1", overflow); end
    run = 1'b1;
    tick();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t5_ovf_clear: got %b want 0", overflow); end
    pulse_sync();
    for (int i = 0; i < 12; i++) send(2, -2);
    wait_beats(4);
    vectors++; if (q_data.size() != 4) begin miscompares++; $display("FAIL t5_beats: got %0d want 4", q_data.size()); end
    for (int j = 0; j < 4 && j < q_data.size(); j++) begin
      vectors++; if (q_data[j] !== ((j == 0) ? expd(4, -4) : expd(8, -8))) begin miscompares++; $display("FAIL t5_data[%0d]: got %h want %h", j, q_data[j], (j == 0) ? expd(4, -4) : expd(8, -8)); end
      vectors++; if (q_user[j] !== ((j == 0) ? 2'd0 : 2'(j - 1))) begin miscompares++; $display("FAIL t5_user[%0d]: got %0d want %0d", j, q_user[j], (j == 0) ? 0 : j - 1); end
    end
  endtask

  task automatic test_async_reset();
    clear_beats();
    m_tready = 1'b0;
    pulse_sync();
    for (int i = 0; i < 10; i++) send(3, -3);
    repeat (3) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t6_busy_pre: got %b want 1", busy); end
    vectors++; if (m_tvalid !== 1'b1) begin miscompares++; $display("FAIL t6_tvalid_pre: got %b want 1", m_tvalid); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL t6_tvalid: got %b want 0", m_tvalid); end
    vectors++; if (m_tdata !== 32'h0) begin miscompares++; $display("FAIL t6_tdata: got %h want 0", m_tdata); end
    vectors++; if ({m_tuser, m_tlast} !== 3'b0) begin miscompares++; $display("FAIL t6_tuser_tlast: got %b want 000", {m_tuser, m_tlast}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy: got %b want 0", busy); end
    tick();
    reset_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(5, -5);
    repeat (4) tick();
    vectors++; if (q_data.size() != 0) begin miscompares++; $display("FAIL t6_no_beats: got %0d want 0", q_data.size()); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL t6_tvalid_post: got %b want 0", m_tvalid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy_post: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_saturation();
    test_backpressure();
    test_run_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
